pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Multi-cycle instruction sequencer for the NPC core. Owns the PC register.
//   Fetches each instruction over a valid/ready request and valid response interface.
//   Holds the instruction while the execute stage works.
//   Computes the next PC from the branch-condition selects (pc_a_src / pc_b_src).
//   Sits between the instruction memory port and decode/execute; drives the PC adder.
// PARAMETERS
//   RESET_PC  32'h8000_0000  PC loaded on reset
//   XLEN      32             PC / data width
// PORTS
//   clk            in   1     single clock; all state updates on rising edge
//   rst            in   1     synchronous, active-high reset
//   ifu_req_valid  out  1     fetch request valid
//   ifu_req_ready  in   1     memory accepts request
//   ifu_req_addr   out  XLEN  fetch address (= pc)
//   ifu_rsp_valid  in   1     fetch response valid (no ready; always accepted in WAIT)
//   ifu_rsp_err    in   1     response carries access fault
//   ifu_rsp_inst   in   32    fetched instruction
//   inst           out  32    latched instruction for decode
//   inst_valid     out  1     high for the whole EXEC state
//   exu_done       in   1     execute finished; pc_a_src/pc_b_src/imm/rs1_data valid
//   pc_a_src       in   1     adder A select: 0 = constant 4, 1 = imm
//   pc_b_src       in   1     adder B select: 0 = current pc, 1 = rs1_data
//   imm            in   XLEN  immediate from decode
//   rs1_data       in   XLEN  register rs1 value
//   halt_req       in   1     ebreak retired (sampled with exu_done)
//   pc             out  XLEN  current PC
//   commit         out  1     one-cycle pulse when pc is updated
//   halted         out  1     sticky halt
//   fault          out  1     sticky; halt caused by error (fetch err / misaligned target)
// BEHAVIOUR
//   - Reset (rst=1 at edge) overrides everything:
//     - pc=RESET_PC, state=FETCH, inst=0.
//     - inst_valid=0, commit=0, halted=0, fault=0.
//     - ifu_req_valid=0 while rst high.
//   - States FETCH, WAIT, EXEC, HALT:
//     - FETCH
//       - ifu_req_valid=1, ifu_req_addr=pc.
//       - Both held stable until ifu_req_valid&&ifu_req_ready; then go to WAIT.
//     - WAIT
//       - ifu_req_valid=0.
//       - On ifu_rsp_valid with err=0: inst<=ifu_rsp_inst; go to EXEC.
//       - On ifu_rsp_valid with err=1: go to HALT with fault=1; pc unchanged.
//     - EXEC
//       - inst_valid=1; wait any number of cycles for exu_done.
//       - On exu_done:
//         - Compute next = (pc_a_src ? imm : 4) + (pc_b_src ? rs1_data : pc), mod 2^XLEN.
//         - If pc_b_src=1 (jalr), clear next[0].
//         - If next[1:0]!=0: go to HALT with fault=1; pc unchanged; no commit.
//         - Else if halt_req=1: go to HALT with fault=0; pc unchanged; commit=1.
//         - Else: pc<=next, commit=1, go to FETCH.
//     - HALT
//       - All request outputs 0; stays in HALT until rst.
//   - ifu_rsp_valid outside WAIT is ignored, including a response in the same cycle as the request handshake.
//   - Inputs other than ifu_* are ignored outside EXEC; exu_done outside EXEC has no effect.
//   - Minimum latency per instruction is 3 cycles (FETCH, WAIT, EXEC), given ready=1, response next cycle, exu_done immediate.
//   - Reset mid-operation: the outstanding response is discarded, because it lands in FETCH and is ignored.
//   - pc wraps 0xFFFF_FFFC + 4 = 0x0000_0000 with no error.
// STRUCTURE
//   - Shared header npc_defs.vh:
//     - state encodings ST_FETCH, ST_WAIT, ST_EXEC, ST_HALT
//     - NPC_RESET_PC
//     - INST_NOP = 32'h0000_0013
//   - Sub-module pc_next_calc (combinational):
//     - inputs pc, imm, rs1_data, pc_a_src, pc_b_src
//     - outputs next_pc and misaligned
//   - All outputs are registered or decoded from the state register only.
// TESTING
//   1. Reset: rst for 2 cycles -> ifu_req_valid=0 during rst; first request addr=0x8000_0000; halted=0.
//   2. Sequential: a=0, b=0, exu_done at pc 0x8000_0000 -> pc=0x8000_0004, one-cycle commit, next request addr 0x8000_0004.
//   3. Branch: pc 0x8000_0010, a=1, b=0, imm=0xFFFF_FFF8 -> pc=0x8000_0008.
//   4. jalr:
//      - rs1=0x8000_0101, imm=3 -> pc=0x8000_0104.
//      - rs1=0x8000_0102, imm=0 -> halted=1, fault=1, pc unchanged, no commit.
//   5. Backpressure: ifu_req_ready=0 for 5 cycles -> valid/addr stable; ifu_rsp_valid pulsed in FETCH is ignored.
//   6. Halts and mid-operation reset:
//      - ifu_rsp_err=1 -> halted=1, fault=1.
//      - halt_req with exu_done -> halted=1, fault=0, commit=1.
//      - rst asserted in WAIT -> FETCH at 0x8000_0000.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the NPC instruction sequencer.
package pc_sequencer_pkg;

   // PC loaded on reset.
   localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;

   // Canonical nop (addi x0, x0, 0).
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   // Sequencer states: one instruction walks FETCH -> WAIT -> EXEC.
   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StWait  = 2'd1,
      StExec  = 2'd2,
      StHalt  = 2'd3
   } state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC adder: (a_src ? imm : 4) + (b_src ? rs1 : pc), with jalr bit-0 clear
// and a misalignment flag on the resulting target.
module pc_next_calc #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_data,
   input  logic            pc_a_src,
   input  logic            pc_b_src,
   output logic [XLEN-1:0] next_pc,
   output logic            misaligned
);

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;

   // Select adder operands, add modulo 2^XLEN, then apply jalr masking.
   always_comb begin
      op_a    = pc_a_src ? imm : XLEN'(4);
      op_b    = pc_b_src ? rs1_data : pc;
      next_pc = op_a + op_b;
      if (pc_b_src) begin
         next_pc[0] = 1'b0;
      end
      misaligned = (next_pc[1:0] != 2'b00);
   end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, fetches over a valid/ready
// request + valid-only response port, holds the instruction during execute and
// advances the PC from the branch-condition selects.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(NPC_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            ifu_req_valid,
   input  logic            ifu_req_ready,
   output logic [XLEN-1:0] ifu_req_addr,
   input  logic            ifu_rsp_valid,
   input  logic            ifu_rsp_err,
   input  logic [31:0]     ifu_rsp_inst,
   output logic [31:0]     inst,
   output logic            inst_valid,
   input  logic            exu_done,
   input  logic            pc_a_src,
   input  logic            pc_b_src,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_data,
   input  logic            halt_req,
   output logic [XLEN-1:0] pc,
   output logic            commit,
   output logic            halted,
   output logic            fault
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q;
   logic [31:0]     inst_q;
   logic            commit_q;
   logic            fault_q;

   logic [XLEN-1:0] next_pc;
   logic            misaligned;
   logic            rsp_take;
   logic            exec_fire;

   pc_next_calc #(
      .XLEN (XLEN)
   ) u_next (
      .pc         (pc_q),
      .imm        (imm),
      .rs1_data   (rs1_data),
      .pc_a_src   (pc_a_src),
      .pc_b_src   (pc_b_src),
      .next_pc    (next_pc),
      .misaligned (misaligned)
   );

   // Responses count only in WAIT; execute results only in EXEC.
   always_comb begin
      rsp_take  = (state_q == StWait) && ifu_rsp_valid;
      exec_fire = (state_q == StExec) && exu_done;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch: if (ifu_req_ready) state_d = StWait;
         StWait:  if (ifu_rsp_valid) state_d = ifu_rsp_err ? StHalt : StExec;
         StExec:  if (exu_done) state_d = (misaligned || halt_req) ? StHalt : StFetch;
         StHalt:  state_d = StHalt;
         default: state_d = StHalt;
      endcase
   end

   // State, PC, instruction latch and sticky flags; reset overrides all.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StFetch;
         pc_q     <= RESET_PC;
         inst_q   <= 32'h0;
         commit_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         commit_q <= exec_fire && !misaligned;
         if (exec_fire && !misaligned && !halt_req) begin
            pc_q <= next_pc;
         end
         if (rsp_take && !ifu_rsp_err) begin
            inst_q <= ifu_rsp_inst;
         end
         if ((rsp_take && ifu_rsp_err) || (exec_fire && misaligned)) begin
            fault_q <= 1'b1;
         end
      end
   end

   // Outputs come from registers or the state register; request is masked in reset.
   always_comb begin
      ifu_req_valid = (state_q == StFetch) && !rst;
      ifu_req_addr  = pc_q;
      inst          = inst_q;
      inst_valid    = (state_q == StExec);
      pc            = pc_q;
      commit        = commit_q;
      halted        = (state_q == StHalt);
      fault         = fault_q;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_pc_sequencer;

   localparam logic [31:0] RPC = 32'h8000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int PH_FETCH = 0;
   localparam int PH_WAIT  = 1;
   localparam int PH_EXEC  = 2;
   localparam int PH_HALT  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifu_req_valid;
   logic        ifu_req_ready = 1'b0;
   logic [31:0] ifu_req_addr;
   logic        ifu_rsp_valid = 1'b0;
   logic        ifu_rsp_err = 1'b0;
   logic [31:0] ifu_rsp_inst = 32'h0;
   logic [31:0] inst;
   logic        inst_valid;
   logic        exu_done = 1'b0;
   logic        pc_a_src = 1'b0;
   logic        pc_b_src = 1'b0;
   logic [31:0] imm = 32'h0;
   logic [31:0] rs1_data = 32'h0;
   logic        halt_req = 1'b0;
   logic [31:0] pc;
   logic        commit;
   logic        halted;
   logic        fault;

   int n_cmp = 0;
   int n_bad = 0;

   pc_sequencer #(
      .XLEN     (32),
      .RESET_PC (RPC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready),
      .ifu_req_addr  (ifu_req_addr),
      .ifu_rsp_valid (ifu_rsp_valid),
      .ifu_rsp_err   (ifu_rsp_err),
      .ifu_rsp_inst  (ifu_rsp_inst),
      .inst          (inst),
      .inst_valid    (inst_valid),
      .exu_done      (exu_done),
      .pc_a_src      (pc_a_src),
      .pc_b_src      (pc_b_src),
      .imm           (imm),
      .rs1_data      (rs1_data),
      .halt_req      (halt_req),
      .pc            (pc),
      .commit        (commit),
      .halted        (halted),
      .fault         (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Reference model: one instruction = fetch handshake, response, execute result.
   int          m_ph = PH_FETCH;
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_inst = 32'h0;
   logic        m_commit = 1'b0;
   logic        m_fault = 1'b0;
   bit          m_init = 1'b0;

   always @(posedge clk) begin : model
      logic [63:0] t;
      m_commit = 1'b0;
      if (rst) begin
         m_init  = 1'b1;
         m_ph    = PH_FETCH;
         m_pc    = RPC;
         m_inst  = 32'h0;
         m_fault = 1'b0;
      end else if (m_init) begin
         case (m_ph)
            PH_FETCH: if (ifu_req_ready) m_ph = PH_WAIT;
            PH_WAIT: if (ifu_rsp_valid) begin
               if (ifu_rsp_err) begin
                  m_fault = 1'b1;
                  m_ph    = PH_HALT;
               end else begin
                  m_inst = ifu_rsp_inst;
                  m_ph   = PH_EXEC;
               end
            end
            PH_EXEC: if (exu_done) begin
               t = (pc_a_src ? {32'd0, imm} : 64'd4) + (pc_b_src ? {32'd0, rs1_data} : {32'd0, m_pc});
               t = t % 64'h1_0000_0000;
               if (pc_b_src) t = t - (t % 2);
               if (t % 4 != 0) begin
                  m_fault = 1'b1;
                  m_ph    = PH_HALT;
               end else if (halt_req) begin
                  m_commit = 1'b1;
                  m_ph     = PH_HALT;
               end else begin
                  m_pc     = t[31:0];
                  m_commit = 1'b1;
                  m_ph     = PH_FETCH;
               end
            end
            default: m_ph = PH_HALT;
         endcase
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_init) begin
         chk("m_req_valid", {31'd0, ifu_req_valid}, {31'd0, (!rst && m_ph == PH_FETCH)});
         chk("m_req_addr", ifu_req_addr, m_pc);
         chk("m_pc", pc, m_pc);
         chk("m_inst", inst, m_inst);
         chk("m_inst_valid", {31'd0, inst_valid}, {31'd0, (m_ph == PH_EXEC)});
         chk("m_commit", {31'd0, commit}, {31'd0, m_commit});
         chk("m_halted", {31'd0, halted}, {31'd0, (m_ph == PH_HALT)});
         chk("m_fault", {31'd0, fault}, {31'd0, m_fault});
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   // Runs one instruction from FETCH; returns with the outcome visible.
   task automatic run_insn(input logic a, input logic b, input logic [31:0] im,
                           input logic [31:0] r1, input logic hr, input logic er,
                           input logic [31:0] exp_addr);
      chk("req_valid_fetch", {31'd0, ifu_req_valid}, 32'd1);
      chk("req_addr_fetch", ifu_req_addr, exp_addr);
      ifu_req_ready = 1'b1;
      step();
      ifu_req_ready = 1'b0;
      chk("req_valid_wait", {31'd0, ifu_req_valid}, 32'd0);
      ifu_rsp_valid = 1'b1;
      ifu_rsp_err   = er;
      ifu_rsp_inst  = NOP;
      step();
      ifu_rsp_valid = 1'b0;
      ifu_rsp_err   = 1'b0;
      if (!er) begin
         chk("inst_valid_exec", {31'd0, inst_valid}, 32'd1);
         chk("inst_exec", inst, NOP);
         pc_a_src = a;
         pc_b_src = b;
         imm      = im;
         rs1_data = r1;
         halt_req = hr;
         exu_done = 1'b1;
         step();
         exu_done = 1'b0;
         halt_req = 1'b0;
      end
   endtask

   initial begin
      int halt_cnt;
      // Reset for two cycles: no request while rst is high.
      step();
      chk("rst_req_valid0", {31'd0, ifu_req_valid}, 32'd0);
      step();
      chk("rst_req_valid1", {31'd0, ifu_req_valid}, 32'd0);
      rst = 1'b0;
      step();
      chk("first_addr", ifu_req_addr, RPC);
      chk("first_halted", {31'd0, halted}, 32'd0);

      // Sequential step.
      run_insn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, RPC);
      chk("seq_pc", pc, 32'h8000_0004);
      chk("seq_commit", {31'd0, commit}, 32'd1);
      step();
      chk("seq_commit_pulse", {31'd0, commit}, 32'd0);
      chk("seq_next_addr", ifu_req_addr, 32'h8000_0004);

      // Forward jump then backward branch.
      run_insn(1'b1, 1'b0, 32'h0000_000C, 32'h0, 1'b0, 1'b0, 32'h8000_0004);
      chk("jump_pc", pc, 32'h8000_0010);
      step();
      run_insn(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0, 32'h8000_0010);
      chk("branch_pc", pc, 32'h8000_0008);
      step();

      // jalr: bit 0 cleared, then a misaligned target.
      run_insn(1'b1, 1'b1, 32'h3, 32'h8000_0101, 1'b0, 1'b0, 32'h8000_0008);
      chk("jalr_pc", pc, 32'h8000_0104);
      step();
      run_insn(1'b1, 1'b1, 32'h0, 32'h8000_0102, 1'b0, 1'b0, 32'h8000_0104);
      chk("mis_pc", pc, 32'h8000_0104);
      chk("mis_commit", {31'd0, commit}, 32'd0);
      chk("mis_halted", {31'd0, halted}, 32'd1);
      chk("mis_fault", {31'd0, fault}, 32'd1);
      step();
      chk("mis_stay_halted", {31'd0, halted}, 32'd1);
      chk("mis_no_req", {31'd0, ifu_req_valid}, 32'd0);

      // Backpressure with a stray response in FETCH and one on the handshake cycle.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", {31'd0, ifu_req_valid}, 32'd1);
         chk("bp_addr", ifu_req_addr, RPC);
         ifu_rsp_valid = (k == 2);
         ifu_rsp_inst  = 32'hDEAD_BEEF;
         step();
      end
      chk("bp_valid_after", {31'd0, ifu_req_valid}, 32'd1);
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = 1'b1;
      step();
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      chk("hs_rsp_ignored", {31'd0, inst_valid}, 32'd0);
      step();
      chk("wait_still", {31'd0, inst_valid}, 32'd0);
      chk("wait_inst", inst, 32'h0);
      ifu_rsp_valid = 1'b1;
      ifu_rsp_inst  = NOP;
      step();
      ifu_rsp_valid = 1'b0;
      chk("bp_exec", {31'd0, inst_valid}, 32'd1);
      // Stay in EXEC a few cycles, then jump to the top of the address space.
      step();
      step();
      chk("exec_hold", {31'd0, inst_valid}, 32'd1);
      pc_a_src = 1'b0;
      pc_b_src = 1'b1;
      rs1_data = 32'hFFFF_FFF8;
      exu_done = 1'b1;
      step();
      exu_done = 1'b0;
      chk("top_pc", pc, 32'hFFFF_FFFC);
      step();
      run_insn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC);
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_fault", {31'd0, fault}, 32'd0);
      step();

      // Fetch error.
      do_reset();
      run_insn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, RPC);
      chk("err_halted", {31'd0, halted}, 32'd1);
      chk("err_fault", {31'd0, fault}, 32'd1);
      chk("err_pc", pc, RPC);

      // Halt request.
      do_reset();
      run_insn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, RPC);
      chk("hr_halted", {31'd0, halted}, 32'd1);
      chk("hr_fault", {31'd0, fault}, 32'd0);
      chk("hr_commit", {31'd0, commit}, 32'd1);
      chk("hr_pc", pc, RPC);

      // Reset while waiting; the late response lands in FETCH.
      do_reset();
      run_insn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, RPC);
      step();
      ifu_req_ready = 1'b1;
      step();
      ifu_req_ready = 1'b0;
      rst = 1'b1;
      step();
      chk("mr_req_in_rst", {31'd0, ifu_req_valid}, 32'd0);
      rst = 1'b0;
      ifu_rsp_valid = 1'b1;
      ifu_rsp_inst  = 32'h1234_5678;
      step();
      ifu_rsp_valid = 1'b0;
      chk("mr_req_valid", {31'd0, ifu_req_valid}, 32'd1);
      chk("mr_addr", ifu_req_addr, RPC);
      chk("mr_inst_valid", {31'd0, inst_valid}, 32'd0);
      step();
      chk("mr_still_fetch", {31'd0, ifu_req_valid}, 32'd1);

      // Randomized traffic; the model comparison runs every cycle.
      do_reset();
      halt_cnt = 0;
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 299) == 0) || (halted && halt_cnt >= 3);
         halt_cnt = halted ? halt_cnt + 1 : 0;
         ifu_req_ready = ($urandom_range(0, 2) != 0);
         ifu_rsp_valid = $urandom_range(0, 1) == 1;
         ifu_rsp_err   = ($urandom_range(0, 49) == 0);
         ifu_rsp_inst  = $urandom;
         exu_done      = ($urandom_range(0, 2) == 0);
         pc_a_src      = $urandom_range(0, 1) == 1;
         pc_b_src      = $urandom_range(0, 1) == 1;
         imm           = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         rs1_data      = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         halt_req      = ($urandom_range(0, 39) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
